ysyx_25050148_sram: RTL
=======================

# ysyx_25050148_sram

AXI4-Lite responder (slave) that serves the CPU's instruction-fetch and load/store initiators from a word-addressed on-chip SRAM. Read (AR/R) and write (AW/W/B) channels run independently. A programmable access latency is inserted before every response, so initiator handshake logic is exercised under realistic memory delay. The block sits between the fetch/LSU bus masters (or an arbiter) and storage.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width (fixed 32; wstrb is 4 bits)
- DEPTH_LOG2, 10, log2 of word count (default 1024 words = 4 KiB)
- BASE_ADDR, 32'h80000000, byte address of word 0
- LATENCY, 2, wait cycles between request capture and response (0 allowed)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- araddr  in  ADDR_WIDTH  read address
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  DATA_WIDTH  read data
- rresp  out  2  read response (00 OKAY, 10 SLVERR)
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- awaddr  in  ADDR_WIDTH  write address
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  DATA_WIDTH  write data
- wstrb  in  4  byte strobes, bit i enables wdata[8i+7:8i]
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  write response (00 OKAY, 10 SLVERR)
- bvalid  out  1  write response valid
- bready  in  1  write response ready

## Operation
- Decode: off = addr - BASE_ADDR; in range iff off < 4*2^DEPTH_LOG2; index = off[DEPTH_LOG2+1:2]; addr[1:0] ignored.
- Read FSM R_IDLE / R_WAIT / R_RESP:
  - R_IDLE: arready=1. On arvalid, latch araddr and load the counter with LATENCY. Go to R_RESP if LATENCY=0, else to R_WAIT.
  - R_WAIT: counter decrements each cycle. On the edge where it reaches 0, go to R_RESP.
  - On entering R_RESP: register rdata=mem[index] and rresp=00. If out of range, rdata=0 and rresp=10.
  - R_RESP: rvalid=1; rdata and rresp held stable until rready, then back to R_IDLE.
- Write FSM W_IDLE / W_WAIT / W_RESP:
  - W_IDLE: awready=1 until the AW handshake, wready=1 until the W handshake. AW and W are accepted in either order or in the same cycle, each latched independently.
  - Once both are held, load the counter with LATENCY and go to W_WAIT, or to W_RESP directly if LATENCY=0.
  - On entering W_RESP: commit the strobed bytes to mem[index] if in range, with bresp=00. If out of range, no commit and bresp=10.
  - W_RESP: bvalid=1 until bready, then W_IDLE. The AW/W latched flags are cleared at that point.
- wstrb=0000: no bytes change, bresp=00.
- Same-edge read sample and write commit to the same index: the read returns the old data (read-before-write).
- One outstanding transaction per channel; no new AR/AW/W is accepted until that channel returns to idle.

## Timing
- Reset values (while rst=0): arready=1, awready=1, wready=1, rvalid=0, bvalid=0, rdata=0, rresp=00, bresp=00, both FSMs idle, counters 0.
- Memory contents are not reset.
- Reset mid-transaction: pending responses are dropped. An uncommitted write never reaches memory.
- Read latency: AR handshake at edge t0, rvalid high after edge t0+LATENCY.
  - LATENCY=0: rvalid high in the cycle after the handshake.
  - Throughput is one read per LATENCY+2 cycles with rready held high.
- Write latency: counted from the edge where the later of AW/W is captured. bvalid rises LATENCY edges after that edge.
- Ready outputs decode directly from state. rdata, rresp, rvalid, bresp and bvalid are registered.

## Test plan
- Reset-release idle check: immediately after reset release, arready=awready=wready=1 and rvalid=bvalid=0.
- Read after write, LATENCY=2:
  - Stimulus: write 0xDEADBEEF to 0x80000010 with wstrb=1111, then read 0x80000010.
  - Response: bvalid 2 cycles after capture with bresp=00; rvalid 2 cycles after the AR handshake with rdata=0xDEADBEEF and rresp=00.
- Byte strobes and address order:
  - Stimulus: W (wdata=0x11223344, wstrb=0101) presented 3 cycles before AW 0x80000010, over the prior 0xDEADBEEF; then read back.
  - Response: awready stays high until the AW handshake; readback = 0xDE22BE44.
- Backpressure: hold rready=0 for 5 cycles with rvalid up. rdata and rresp stay constant, arready stays 0, and the transfer completes on the first rready=1.
- Out of range:
  - Read 0x80001000: rdata=0, rresp=10.
  - Write 0x7FFFFFFC: bresp=10, and the word-0 contents are unchanged.
- Collision and reset:
  - Same-edge read/write to the same index: the read returns the old value.
  - rst pulsed low during W_WAIT: bvalid=0 afterwards, memory unchanged.

Source files
------------

// File: rtl/ysyx_25050148_sram_if.sv
// ysyx_25050148_sram_if: AXI4-Lite read/write channel bundle between a bus master and the SRAM responder
interface ysyx_25050148_sram_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_25050148_sram.sv
// ysyx_25050148_sram: AXI4-Lite word-addressed SRAM responder with programmable response latency
module ysyx_25050148_sram #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH_LOG2 = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h80000000,
  parameter int                    LATENCY    = 2
) (
  input logic                  clk,
  input logic                  rst,
  ysyx_25050148_sram_if.slave  bus
);
  localparam int CW = LATENCY < 1 ? 1 : $clog2(LATENCY + 1);
  localparam logic [CW-1:0] LAT = CW'(LATENCY);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(64'd4 << DEPTH_LOG2);
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
  logic [DATA_WIDTH-1:0] r_mem [2**DEPTH_LOG2];
  r_state_t              r_rs, w_rs_nx;
  logic [ADDR_WIDTH-1:0] r_araddr, w_raddr, w_roff;
  logic [CW-1:0]         r_rcnt;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic                  r_rvalid, w_ar_hs, w_rload, w_rin;
  logic [DEPTH_LOG2-1:0] w_ridx;
  w_state_t              r_ws, w_ws_nx;
  logic [ADDR_WIDTH-1:0] r_awaddr, w_waddr, w_woff;
  logic [DATA_WIDTH-1:0] r_wdata, w_wd;
  logic [3:0]            r_wstrb, w_wsb;
  logic [CW-1:0]         r_wcnt;
  logic [1:0]            r_bresp;
  logic                  r_bvalid, r_awok, r_wok, w_aw_hs, w_w_hs, w_both, w_commit, w_win;
  logic [DEPTH_LOG2-1:0] w_widx;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_rs <= R_IDLE;
    else r_rs <= w_rs_nx;
  always_comb begin
    w_ar_hs = r_rs == R_IDLE && bus.arvalid;
    w_rs_nx = r_rs == R_IDLE ? (bus.arvalid ? (LATENCY == 0 ? R_RESP : R_WAIT) : R_IDLE)
            : r_rs == R_WAIT ? (r_rcnt == ONE ? R_RESP : R_WAIT)
            : (bus.rready ? R_IDLE : R_RESP);
    w_rload = w_rs_nx == R_RESP && r_rs != R_RESP;
    w_raddr = r_rs == R_IDLE ? bus.araddr : r_araddr;
    w_roff  = w_raddr - BASE_ADDR;
    w_rin   = w_roff < SPAN;
    w_ridx  = w_roff[DEPTH_LOG2+1:2];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_araddr <= '0;
      r_rcnt   <= '0;
      r_rdata  <= '0;
      r_rresp  <= 2'b00;
      r_rvalid <= 1'b0;
    end else begin
      if (w_ar_hs) r_araddr <= bus.araddr;
      r_rcnt <= w_ar_hs ? LAT : r_rs == R_WAIT ? r_rcnt - ONE : r_rcnt;
      if (w_rload) begin
        r_rdata <= w_rin ? r_mem[w_ridx] : '0;
        r_rresp <= w_rin ? 2'b00 : 2'b10;
      end
      r_rvalid <= w_rs_nx == R_RESP;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_ws <= W_IDLE;
    else r_ws <= w_ws_nx;
  always_comb begin
    w_aw_hs  = r_ws == W_IDLE && !r_awok && bus.awvalid;
    w_w_hs   = r_ws == W_IDLE && !r_wok && bus.wvalid;
    w_both   = r_ws == W_IDLE && (r_awok || w_aw_hs) && (r_wok || w_w_hs);
    w_ws_nx  = r_ws == W_IDLE ? (w_both ? (LATENCY == 0 ? W_RESP : W_WAIT) : W_IDLE)
             : r_ws == W_WAIT ? (r_wcnt == ONE ? W_RESP : W_WAIT)
             : (bus.bready ? W_IDLE : W_RESP);
    w_commit = w_ws_nx == W_RESP && r_ws != W_RESP;
    w_waddr  = r_awok ? r_awaddr : bus.awaddr;
    w_wd     = r_wok ? r_wdata : bus.wdata;
    w_wsb    = r_wok ? r_wstrb : bus.wstrb;
    w_woff   = w_waddr - BASE_ADDR;
    w_win    = w_woff < SPAN;
    w_widx   = w_woff[DEPTH_LOG2+1:2];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_awok   <= 1'b0;
      r_wok    <= 1'b0;
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_wcnt   <= '0;
      r_bresp  <= 2'b00;
      r_bvalid <= 1'b0;
    end else begin
      if (w_aw_hs) r_awaddr <= bus.awaddr;
      if (w_w_hs) begin
        r_wdata <= bus.wdata;
        r_wstrb <= bus.wstrb;
      end
      r_awok   <= r_ws == W_RESP && bus.bready ? 1'b0 : r_awok || w_aw_hs;
      r_wok    <= r_ws == W_RESP && bus.bready ? 1'b0 : r_wok || w_w_hs;
      r_wcnt   <= w_both ? LAT : r_ws == W_WAIT ? r_wcnt - ONE : r_wcnt;
      if (w_commit) r_bresp <= w_win ? 2'b00 : 2'b10;
      r_bvalid <= w_ws_nx == W_RESP;
    end
  // storage is deliberately unreset; the nonblocking write keeps same-edge reads returning old data
  always_ff @(posedge clk)
    if (w_commit && w_win)
      for (int i = 0; i < 4; i++)
        if (w_wsb[i]) r_mem[w_widx][8*i +: 8] <= w_wd[8*i +: 8];
  always_comb begin
    bus.arready = r_rs == R_IDLE;
    bus.rvalid  = r_rvalid;
    bus.rdata   = r_rdata;
    bus.rresp   = r_rresp;
    bus.awready = r_ws == W_IDLE && !r_awok;
    bus.wready  = r_ws == W_IDLE && !r_wok;
    bus.bvalid  = r_bvalid;
    bus.bresp   = r_bresp;
  end
endmodule
